// File: rtl/qeciphy_pkg.sv
// Shared QECIPHY definitions: receive FSM state encoding and the CRC-8/SMBUS
// byte step used by both the receive validator and the transmit generator.
package qeciphy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        BODY  = 2'd2
    } rx_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first, unreflected, one byte per call.
    function automatic logic [7:0] crc8_smbus_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/qeciphy_crc8_smbus.sv
// Running CRC-8/SMBUS accumulator; clear takes priority over an accepted byte.
module qeciphy_crc8_smbus
    import qeciphy_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tdata_i,
    input  logic       tvalid_i,
    input  logic       clear_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 8'h00;
        end else if (tvalid_i) begin
            crc_d = crc8_smbus_step(crc_q, tdata_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) crc_q <= 8'h00;
        else          crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/qeciphy_rx_crc8_validator.sv
// Receive-side CRC-8 check: delays the stream by one byte so the trailing CRC
// byte can be stripped, and reports a per-frame verdict plus a bad-frame count.
module qeciphy_rx_crc8_validator
    import qeciphy_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       s_tdata_i,
    input  logic             s_tvalid_i,
    input  logic             s_tlast_i,
    output logic [7:0]       m_tdata_o,
    output logic             m_tvalid_o,
    output logic             m_tlast_o,
    output logic             frame_done_o,
    output logic             frame_ok_o,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             err_cnt_clr_i
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

    rx_state_e        state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic [7:0]       m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q, m_tlast_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [7:0]       crc_q, crc_fin;

    qeciphy_crc8_smbus u_crc (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .tdata_i  (s_tdata_i),
        .tvalid_i (s_tvalid_i),
        .clear_i  (s_tvalid_i & s_tlast_i),
        .crc_o    (crc_q)
    );

    // Verdict must land in the same cycle as the last payload byte, so the
    // final CRC step over the CRC byte is evaluated here rather than waited for.
    assign crc_fin = crc8_smbus_step(crc_q, s_tdata_i);
    assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        len_d      = len_q;
        m_tdata_d  = 8'h00;
        m_tvalid_d = 1'b0;
        m_tlast_d  = 1'b0;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        if (s_tvalid_i) begin
            case (state_q)
                IDLE: begin
                    if (s_tlast_i) begin
                        done_d = 1'b1;
                        len_d  = '0;
                    end else begin
                        hold_d  = s_tdata_i;
                        len_d   = LEN_W'(1);
                        state_d = FIRST;
                    end
                end
                FIRST, BODY: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = hold_q;
                    if (s_tlast_i) begin
                        m_tlast_d = 1'b1;
                        done_d    = 1'b1;
                        ok_d      = (crc_fin == 8'h00) && (len_inc >= LEN_MIN) && (len_inc <= LEN_MAX);
                        len_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        hold_d  = s_tdata_i;
                        len_d   = len_inc;
                        state_d = BODY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counts from the registered verdict so a clear in the done cycle wins.
    always_comb begin
        err_d = err_q;
        if (err_cnt_clr_i) begin
            err_d = '0;
        end else if (done_q && !ok_q && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            hold_q     <= 8'h00;
            len_q      <= '0;
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign m_tdata_o    = m_tdata_q;
    assign m_tvalid_o   = m_tvalid_q;
    assign m_tlast_o    = m_tlast_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_qeciphy_rx_crc8_validator.sv
// Directed bench: default instance (a) and a MAX_LEN=4 / CNT_W=2 instance (b)
// share one input stream; outputs are logged at the falling edge.
module tb_qeciphy_rx_crc8_validator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;

    logic [7:0]  a_md, b_md;
    logic        a_mv, a_ml, a_fd, a_ok, b_mv, b_ml, b_fd, b_ok;
    logic [15:0] a_err;
    logic [1:0]  b_err;

    always #5 clk = ~clk;

    qeciphy_rx_crc8_validator dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tlast_i(tlast),
        .m_tdata_o(a_md), .m_tvalid_o(a_mv), .m_tlast_o(a_ml), .frame_done_o(a_fd),
        .frame_ok_o(a_ok), .err_cnt_o(a_err), .err_cnt_clr_i(clr_a)
    );

    qeciphy_rx_crc8_validator #(.MAX_LEN(4), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tlast_i(tlast),
        .m_tdata_o(b_md), .m_tvalid_o(b_mv), .m_tlast_o(b_ml), .frame_done_o(b_fd),
        .frame_ok_o(b_ok), .err_cnt_o(b_err), .err_cnt_clr_i(clr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Payload log {tlast,data}; verdict log {m_tvalid,m_tlast,frame_ok}.
    logic [8:0] a_out[$], b_out[$];
    logic [2:0] a_done[$], b_done[$];

    always @(negedge clk) begin
        if (a_mv) a_out.push_back({a_ml, a_md});
        if (b_mv) b_out.push_back({b_ml, b_md});
        if (a_fd) a_done.push_back({a_mv, a_ml, a_ok});
        if (b_fd) b_done.push_back({b_mv, b_ml, b_ok});
    end

    task automatic clear_logs();
        a_out.delete(); b_out.delete(); a_done.delete(); b_done.delete();
    endtask

    task automatic send(input logic [7:0] d[$], input bit gaps);
        for (int i = 0; i < d.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    tvalid = 1'b0;
                    tlast  = 1'b0;
                end
            end
            @(negedge clk);
            tdata  = d[i];
            tvalid = 1'b1;
            tlast  = (i == d.size() - 1);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_digits(input string tag, input bit a_ok_exp);
        chk({tag, "_n"}, a_out.size(), 9);
        for (int i = 0; i < 9 && i < a_out.size(); i++)
            chk({tag, "_byte"}, a_out[i], {(i == 8), 8'(8'h31 + i)});
        chk({tag, "_done_n"}, a_done.size(), 1);
        if (a_done.size() > 0) chk({tag, "_verdict"}, a_done[0], {2'b11, a_ok_exp});
    endtask

    logic [7:0] fr[$];

    initial begin
        // Held in reset
        repeat (3) @(negedge clk);
        chk("rst_mv", a_mv, 0);
        chk("rst_ml", a_ml, 0);
        chk("rst_fd", a_fd, 0);
        chk("rst_ok", a_ok, 0);
        chk("rst_err", a_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good two-byte frame, checked cycle by cycle for latency
        tdata = 8'h01; tvalid = 1'b1; tlast = 1'b0;
        @(negedge clk);
        chk("g2_first_quiet", {a_mv, a_fd}, 2'b00);
        tdata = 8'h07; tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        chk("g2_out", {a_mv, a_ml, a_md}, {2'b11, 8'h01});
        chk("g2_done", {a_fd, a_ok}, 2'b11);
        chk("g2_b_done", {b_fd, b_ok}, 2'b11);
        @(negedge clk);
        chk("g2_idle_after", {a_mv, a_ml, a_fd, a_ok}, 4'b0000);
        chk("g2_err", a_err, 0);
        repeat (2) @(negedge clk);
        clear_logs();

        // "123456789" with correct CRC 0xF4, then wrong CRC 0xF5
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
        fr.push_back(8'hF4);
        send(fr, 1'b0);
        chk_digits("std_good", 1'b1);
        chk("std_good_err", a_err, 0);
        chk("std_b_long_err", b_err, 1);
        clear_logs();
        fr[9] = 8'hF5;
        send(fr, 1'b0);
        chk_digits("std_bad", 1'b0);
        chk("std_bad_err", a_err, 1);
        clear_logs();

        // Runt
        fr = {8'h00};
        send(fr, 1'b0);
        chk("runt_out_n", a_out.size(), 0);
        chk("runt_done_n", a_done.size(), 1);
        if (a_done.size() > 0) chk("runt_verdict", a_done[0], 3'b000);
        chk("runt_err", a_err, 2);
        chk("runt_b_err", b_err, 3);
        clear_logs();

        // Five bytes with valid CRC: fine for MAX_LEN=64, overlong for MAX_LEN=4
        fr = {8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
        send(fr, 1'b0);
        chk("long_b_out_n", b_out.size(), 4);
        if (b_out.size() == 4) chk("long_b_last", b_out[3], 9'h101);
        if (b_out.size() == 4) chk("long_b_first", b_out[0], 9'h000);
        chk("long_b_done_n", b_done.size(), 1);
        if (b_done.size() > 0) chk("long_b_verdict", b_done[0], 3'b110);
        if (a_done.size() > 0) chk("long_a_verdict", a_done[0], 3'b111);
        chk("long_b_err_sat", b_err, 3);
        chk("long_a_err", a_err, 2);
        clear_logs();

        // Exactly MAX_LEN bytes on instance b
        fr = {8'h00, 8'h00, 8'h01, 8'h07};
        send(fr, 1'b0);
        chk("max_b_done_n", b_done.size(), 1);
        if (b_done.size() > 0) chk("max_b_verdict", b_done[0], 3'b111);
        clear_logs();

        // Same standard frame with random valid gaps
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
        fr.push_back(8'hF4);
        send(fr, 1'b1);
        chk_digits("gap", 1'b1);
        chk("gap_err", a_err, 2);
        clear_logs();

        // Reset in the middle of a frame, then a good frame
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tdata = 8'(8'h31 + i); tvalid = 1'b1; tlast = 1'b0;
        end
        @(negedge clk);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_mv", a_mv, 0);
        chk("mid_rst_err", a_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        fr = {8'h01, 8'h07};
        send(fr, 1'b0);
        chk("mid_rst_done_n", a_done.size(), 1);
        if (a_done.size() > 0) chk("mid_rst_verdict", a_done[0], 3'b111);
        chk("mid_rst_out_n", a_out.size(), 1);
        if (a_out.size() > 0) chk("mid_rst_out", a_out[0], 9'h101);
        clear_logs();

        // Counter saturation on the 2-bit instance
        fr = {8'h00};
        repeat (5) send(fr, 1'b0);
        chk("sat_b_err", b_err, 3);
        chk("sat_a_err", a_err, 5);

        // Clear coinciding with a bad frame's done pulse
        @(negedge clk);
        tdata = 8'h00; tvalid = 1'b1; tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        chk("clr_b_fd", {b_fd, b_ok}, 2'b10);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("clr_b_err", b_err, 0);
        chk("clr_a_err", a_err, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qeciphy_rx_crc8_validator.md
QECIPHY_RX_CRC8_VALIDATOR -- requirements
Module: qeciphy_rx_crc8_validator

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 64, meaning the maximum frame length in bytes, including the CRC byte.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the error counter.
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset: clk_i (input, 1 bit, clock) and rst_n_i (input, 1 bit, reset).
REQ-004 s_tdata_i (input, 8 bits) SHALL carry the received byte.
REQ-005 s_tvalid_i (input, 1 bit) SHALL qualify the byte; there is no backpressure.
REQ-006 s_tlast_i (input, 1 bit) SHALL mark the final byte of a frame, which is the CRC byte.
REQ-007 m_tdata_o (output, 8 bits) SHALL carry payload bytes with the CRC byte stripped.
REQ-008 m_tvalid_o and m_tlast_o (outputs, 1 bit each) SHALL qualify the payload byte and mark the last payload byte.
REQ-009 frame_done_o (output, 1 bit) SHALL be a one-cycle pulse when a frame's result is available.
REQ-010 frame_ok_o (output, 1 bit) SHALL be the frame result, valid only while frame_done_o is high.
REQ-011 err_cnt_o (output, CNT_W bits) SHALL be a saturating count of bad frames.
REQ-012 err_cnt_clr_i (input, 1 bit) SHALL synchronously clear err_cnt_o.

Function
REQ-013 CRC SHALL be CRC-8/SMBUS: polynomial 0x07, initial value 0x00, MSB-first, no reflection, no final XOR.
REQ-014 The running CRC SHALL cover every accepted byte of the frame, including the CRC byte; a frame is good when the final CRC is 0x00.
REQ-015 The block SHALL implement the FSM states IDLE, FIRST and BODY.
REQ-016 Gaps in s_tvalid_i SHALL be allowed in every state; the FSM, CRC and counters hold while s_tvalid_i is low.
REQ-017 In IDLE, a valid byte without tlast SHALL be stored in the hold register, seed the CRC and length=1, and move the FSM to FIRST; nothing is emitted.
REQ-018 In FIRST or BODY, a valid byte without tlast SHALL cause the held byte to be emitted (m_tvalid_o=1, m_tlast_o=0) on the next cycle, the new byte to be held, CRC and length to be updated, and the FSM to move to BODY.
REQ-019 In FIRST or BODY, a valid byte with tlast SHALL cause, on the next cycle, the held byte to be emitted with m_tlast_o=1 and frame_done_o=1, and the FSM to return to IDLE with the CRC cleared.
REQ-020 frame_ok_o SHALL be 1 only if the final CRC is 0x00 and the frame length is in the range 2..MAX_LEN.
REQ-021 Runt frame: a valid byte with tlast in IDLE SHALL cause, on the next cycle, frame_done_o=1 and frame_ok_o=0 with no m_tvalid_o, and the FSM to stay in IDLE.
REQ-022 Overlong frame: the length counter SHALL saturate at MAX_LEN+1; the data still passes through unchanged and the frame is reported with frame_ok_o=0.
REQ-023 Output latency SHALL be exactly one cycle after the triggering input byte, and all outputs SHALL be registered.
REQ-024 err_cnt_o SHALL increment on each frame_done_o pulse with frame_ok_o=0 and hold at all-ones.
REQ-025 If err_cnt_clr_i and an increment occur in the same cycle, the clear SHALL win and the result SHALL be 0.
REQ-026 Outside the cycles defined above, m_tvalid_o, m_tlast_o and frame_done_o SHALL be 0.

Reset
REQ-027 While rst_n_i is low, the FSM SHALL be IDLE; CRC, length, hold register and err_cnt_o SHALL be 0; and all m_* outputs, frame_done_o and frame_ok_o SHALL be 0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame, and the first valid byte after deassertion SHALL start a new frame.

Structure
REQ-029 The CRC-8/SMBUS byte-step function and the FSM state enum SHALL live in the shared qeciphy package, so that they are reusable by the transmit-side generator.
REQ-030 The CRC accumulator SHALL be a sub-module named qeciphy_crc8_smbus, with inputs tdata/tvalid/clear and a registered crc output.
REQ-031 All remaining logic (FSM, hold register, length counter and error counter) SHALL be in this module.

Verification
REQ-032 Good frame: bytes 0x01, 0x07(tlast) -> one output byte 0x01 with m_tlast_o=1; frame_done_o=1 and frame_ok_o=1 in the same cycle; err_cnt_o=0.
REQ-033 Standard vector: bytes "123456789" (0x31..0x39) followed by 0xF4(tlast) -> nine payload bytes with m_tlast_o on 0x39 and frame_ok_o=1; the same frame with the CRC byte 0xF5 -> frame_ok_o=0 and err_cnt_o=1.
REQ-034 Runt frame: the single byte 0x00 with tlast -> frame_done_o=1, frame_ok_o=0, no m_tvalid_o, err_cnt_o increments.
REQ-035 Overlong frame: with MAX_LEN=4, send 5 bytes with a correct CRC -> all 4 payload bytes are emitted and frame_ok_o=0.
REQ-036 Gaps and reset: a frame with random s_tvalid_i gaps gives results identical to the gapless frame; asserting rst_n_i low mid-frame followed by a good frame -> exactly one frame_done_o with frame_ok_o=1.
REQ-037 Saturation: with CNT_W=2, send 5 bad frames -> err_cnt_o=3; assert err_cnt_clr_i together with a bad frame's frame_done_o -> err_cnt_o=0.
